rr_arb_161: RTL

- Round-robin arbiter/sequencer that shares one 16:1 single-bit mux between 16 requesters.
- Registers the 4-bit select for the mux, a one-hot grant back to the requesters, and a valid flag qualifying the mux output Y.
- Bounds each tenure with a programmable hold limit so no requester can starve the others.
- Sits directly in front of the mux: its S output drives the mux select S.

---
 rtl/arb161_pkg.sv | 13 +
 rtl/rr_pick16.sv | 27 ++
 rtl/rr_arb_161.sv | 100 ++++++++++
 3 files changed

// File: rtl/arb161_pkg.sv
// rtl/arb161_pkg.sv - shared types and sizes for the 16-way round-robin mux arbiter
package arb161_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - combinational rotating priority encoder, first set req bit at or after ptr
module rr_pick16
    import arb161_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] k;

    always_comb begin
        idx = '0;
        any = 1'b0;
        k   = '0;
        // Walk ptr, ptr+1, ... wrapping mod 16; the first hit wins.
        for (int i = 0; i < N_REQ; i++) begin
            k = ptr + SEL_W'(i);
            if (!any && req[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_161.sv
// rtl/rr_arb_161.sv - round-robin arbiter driving a 16:1 mux select; ARB161_PARK_EN parks S while idle
module rr_arb_161
    import arb161_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int N_REQ    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [N_REQ-1:0] REQ,
    output logic [SEL_W-1:0] S,
    output logic [N_REQ-1:0] GNT,
    output logic             VALID
);

`ifdef ARB161_PARK_EN
    localparam logic PARK = 1'b1;
`else
    localparam logic PARK = 1'b0;
`endif

    state_t            state, state_nx;
    logic [SEL_W-1:0]  ptr, ptr_nx, s_nx, pick_ptr, pick_idx;
    logic [N_REQ-1:0]  gnt_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              valid_nx, pick_any, rel;

    // While granted, the next winner is searched from the slot after S so the
    // current holder lands last in order.
    assign pick_ptr = (state == GRANT) ? S + SEL_W'(1) : ptr;

    rr_pick16 u_pick (
        .req (REQ),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign rel = !REQ[S] || ((MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD))) || !EN;

    always_comb begin
        state_nx = state;
        s_nx     = S;
        gnt_nx   = GNT;
        valid_nx = VALID;
        ptr_nx   = ptr;
        hold_nx  = hold;
        case (state)
            IDLE: begin
                if (EN && pick_any) begin
                    state_nx         = GRANT;
                    s_nx             = pick_idx;
                    gnt_nx           = '0;
                    gnt_nx[pick_idx] = 1'b1;
                    valid_nx         = 1'b1;
                    hold_nx          = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!rel) begin
                    hold_nx = (hold == {HOLD_W{1'b1}}) ? hold : hold + HOLD_W'(1);
                end else begin
                    ptr_nx = S + SEL_W'(1);
                    if (EN && pick_any) begin
                        s_nx             = pick_idx;
                        gnt_nx           = '0;
                        gnt_nx[pick_idx] = 1'b1;
                        hold_nx          = HOLD_W'(1);
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        valid_nx = 1'b0;
                        s_nx     = PARK ? S : '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            S     <= '0;
            GNT   <= '0;
            VALID <= 1'b0;
            ptr   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            S     <= s_nx;
            GNT   <= gnt_nx;
            VALID <= valid_nx;
            ptr   <= ptr_nx;
            hold  <= hold_nx;
        end
    end

endmodule
